// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the instruction encoder.
//   - in_kind descriptor codes (3 bits)
//   - the five RV32I major opcodes used by the encoder
//   - the canonical NOP word (addi x0, x0, 0)
//   - encoder FSM state type
package riscv_pkg;

    // Descriptor kinds; codes 5..7 are invalid and encode as NOP.
    localparam logic [2:0] KindLoad   = 3'd0;
    localparam logic [2:0] KindStore  = 3'd1;
    localparam logic [2:0] KindRtype  = 3'd2;
    localparam logic [2:0] KindItype  = 3'd3;
    localparam logic [2:0] KindBranch = 3'd4;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [31:0] NopWord = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StError
    } enc_state_e;

    function automatic logic kind_is_valid(input logic [2:0] kind);
        return kind <= KindBranch;
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// instr_field_encoder: purely combinational packing of one instruction
// descriptor into a 32-bit RV32I word.
// Ports:
//   kind_i      descriptor kind (riscv_pkg Kind* codes)
//   rd_i, rs1_i, rs2_i   register indices
//   funct3_i, funct7b5_i function fields (funct7 = {0, b5, 00000})
//   imm_i       13-bit immediate / branch byte offset, truncated to field bits
//   word_o      encoded instruction (NOP for an invalid kind)
//   valid_o     0 when kind_i is not a supported kind
module instr_field_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        valid_o
);

    always_comb begin
        word_o  = NopWord;
        valid_o = kind_is_valid(kind_i);
        case (kind_i)
            KindLoad:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpLoad};
            KindStore:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OpStore};
            KindRtype:  word_o = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i,
                                  OpRtype};
            KindItype:  word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpItype};
            // Branch offsets are even; bit 0 is not encoded.
            KindBranch: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1],
                                  imm_i[11], OpBranch};
            default:    word_o = NopWord;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts a stream of instruction descriptors and writes the
// encoded words to consecutive instruction-memory addresses.
// Optional feature: define IMM_RANGE_CHECK_EN to reject descriptors whose
// immediate does not fit its field (write suppressed, err set, ERROR state).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr           begin a load at {base_addr[31:2],2'b00} (IDLE/ERROR only)
//   in_valid, in_ready         descriptor handshake; in_ready is high only in RUN
//   in_kind .. in_imm, in_last descriptor fields; in_last ends the program
//   mem_we, mem_addr, mem_wdata registered write port, one cycle after accept
//   busy, done, err            status (busy in RUN/DONE, done for one cycle, sticky err)
//   instr_count                saturating count of words written since start
module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [12:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] instr_count
);

    enc_state_e  state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        enc_valid;
    logic        imm_bad;
    logic        accept;

    // Low address bits are forced to zero, so they are deliberately dropped.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^base_addr[1:0];

    instr_field_encoder u_field_encoder (
        .kind_i     (in_kind),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7b5_i (in_funct7b5),
        .imm_i      (in_imm),
        .word_o     (enc_word),
        .valid_o    (enc_valid)
    );

`ifdef IMM_RANGE_CHECK_EN
    // 12-bit fields need imm[12] == imm[11]; branch offsets must be even.
    always_comb begin
        imm_bad = 1'b0;
        case (in_kind)
            KindLoad, KindStore, KindItype: imm_bad = in_imm[12] ^ in_imm[11];
            KindBranch:                     imm_bad = in_imm[0];
            default:                        imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    assign accept = in_valid && (state_q == StRun);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            StIdle, StError: begin
                if (start) begin
                    state_d = StRun;
                    ptr_d   = {base_addr[31:2], 2'b00};
                    count_d = 16'd0;
                    err_d   = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    if (imm_bad) begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + 32'd4;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                        if (!enc_valid) begin
                            err_d = 1'b1;
                        end
                        if (in_last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 32'd0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready    = (state_q == StRun);
    assign busy        = (state_q == StRun) || (state_q == StDone);
    assign done        = (state_q == StDone);
    assign err         = err_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a scoreboard queue of expected
// {address, word} pairs is filled as descriptors are accepted and drained by
// a monitor whenever mem_we is seen.
module tb_instr_encoder;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [12:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] instr_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] ptr_m;
    logic [15:0] cnt_m;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_we", {31'd0, mem_we}, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check_eq("wr_addr", mem_addr, e[63:32]);
                check_eq("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // Called on a negedge; returns on a negedge.
    task automatic start_load(input logic [31:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        ptr_m = {b[31:2], 2'b00};
        cnt_m = 16'd0;
    endtask

    // Drive one descriptor; wr=0 means the write is expected to be suppressed.
    task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic b5,
                        input logic [12:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic wr);
        int guard;
        guard       = 0;
        in_valid    = 1'b1;
        in_kind     = k;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_imm      = imm;
        in_last     = last;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
        end else if (wr) begin
            sb_q.push_back({ptr_m, exp_word});
            ptr_m = ptr_m + 32'd4;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Cycle after the last accept: DONE for exactly one cycle, then IDLE.
    task automatic expect_done();
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("done_busy", {31'd0, busy}, 32'd1);
        check_eq("done_ready", {31'd0, in_ready}, 32'd0);
        check_eq("done_count", {16'd0, instr_count}, {16'd0, cnt_m});
        @(negedge clk);
        check_eq("done_clear", {31'd0, done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_kind = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_imm = '0; in_last = 1'b0;
        ptr_m = '0; cnt_m = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_count", {16'd0, instr_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // RTYPE, b5 = 0
        start_load(32'h0000_0100);
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_ready", {31'd0, in_ready}, 32'd1);
        send(KindRtype, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 32'h0020_81B3, 1'b1);
        expect_done();

        // RTYPE, b5 = 1
        start_load(32'h0000_0100);
        send(KindRtype, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 1'b1, 32'h4020_81B3, 1'b1);
        expect_done();

        // LOAD then STORE
        start_load(32'h0000_0100);
        send(KindLoad, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'd8, 1'b0, 32'h0081_2283, 1'b1);
        check_eq("mid_count", {16'd0, instr_count}, 32'd1);
        send(KindStore, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 13'd12, 1'b1, 32'h0051_2623, 1'b1);
        expect_done();

        // BRANCH, offset -8
        start_load(32'h0000_0100);
        send(KindBranch, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1, 32'hFE20_8CE3, 1'b1);
        expect_done();

        // Pointer wrap at the top of the address space
        start_load(32'hFFFF_FFFC);
        send(KindItype, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd1, 1'b0, 32'h0010_0093, 1'b1);
        send(KindItype, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 13'd2, 1'b1, 32'h0020_0113, 1'b1);
        expect_done();

        // Base LSBs dropped; start while in RUN is ignored
        start_load(32'h0000_0203);
        send(KindItype, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'd0, 1'b0, 32'h0000_8093, 1'b1);
        start = 1'b1; base_addr = 32'h0000_0800;
        @(negedge clk);
        start = 1'b0;
        check_eq("ign_start_cnt", {16'd0, instr_count}, 32'd1);
        send(KindRtype, 5'd4, 5'd4, 5'd4, 3'd7, 1'b0, 13'd0, 1'b1, 32'h0042_7233, 1'b1);
        expect_done();

        // Invalid kind writes NOP, err sticky until the next start
        start_load(32'h0000_0300);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 1'b0, 32'h0000_0013, 1'b1);
        check_eq("inv_err", {31'd0, err}, 32'd1);
        check_eq("inv_ready", {31'd0, in_ready}, 32'd1);
        send(KindRtype, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 32'h0020_81B3, 1'b1);
        expect_done();
        check_eq("inv_err_idle", {31'd0, err}, 32'd1);
        start_load(32'h0000_0400);
        check_eq("start_clr_err", {31'd0, err}, 32'd0);

`ifdef IMM_RANGE_CHECK_EN
        // Out-of-range immediate: no write, ERROR, then restart
        send(KindItype, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h0800, 1'b0, 32'd0, 1'b0);
        check_eq("rc_we", {31'd0, mem_we}, 32'd0);
        check_eq("rc_err", {31'd0, err}, 32'd1);
        check_eq("rc_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rc_busy", {31'd0, busy}, 32'd0);
        check_eq("rc_done", {31'd0, done}, 32'd0);
        check_eq("rc_count", {16'd0, instr_count}, 32'd0);
        start_load(32'h0000_0400);
        check_eq("rc_restart", {31'd0, busy}, 32'd1);
        check_eq("rc_restart_err", {31'd0, err}, 32'd0);
        send(KindBranch, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h0005, 1'b1, 32'd0, 1'b0);
        check_eq("rc_br_err", {31'd0, err}, 32'd1);
        check_eq("rc_br_done", {31'd0, done}, 32'd0);
        start_load(32'h0000_0400);
        send(KindBranch, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1, 32'hFE20_8CE3, 1'b1);
        expect_done();
`else
        // Out-of-range immediate is truncated and written
        send(KindItype, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h0800, 1'b1, 32'h8000_0093, 1'b1);
        check_eq("trunc_err", {31'd0, err}, 32'd0);
        expect_done();
`endif

        // Reset mid-RUN, landing just after an accept edge
        start_load(32'h0000_0500);
        send(KindLoad, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'd8, 1'b0, 32'h0081_2283, 1'b1);
        in_valid = 1'b1; in_kind = KindRtype; in_last = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mrst_we", {31'd0, mem_we}, 32'd0);
        check_eq("mrst_addr", mem_addr, 32'd0);
        check_eq("mrst_wdata", mem_wdata, 32'd0);
        check_eq("mrst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_done", {31'd0, done}, 32'd0);
        check_eq("mrst_err", {31'd0, err}, 32'd0);
        check_eq("mrst_count", {16'd0, instr_count}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("post_rst_we", {31'd0, mem_we}, 32'd0);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
